// File: rtl/bop_ctrl_pkg.sv
// Shared definitions for the BOP sequencer: prediction width and FSM states.
package bop_ctrl_pkg;

  localparam int BOP_WIDTH = 32;

  typedef enum logic [1:0] {
    BOPC_INIT = 2'd0,
    BOPC_RUN  = 2'd1,
    BOPC_HOLD = 2'd2
  } bopc_state_t;

endpackage

// File: rtl/bop_ctrl.sv
// Sequencer between the fetch predictor, MA-stage evaluation and the external
// buffer of predictions (BOP). Gates push/pop/flush, stalls fetch when the BOP
// has no room, and keeps a credit count of stored predictions that is
// cross-checked against the BOP status flags to catch upsets.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// BOPC_INIT | after reset: BOP flushed, fetch stalled for INIT_CYCLES
// BOPC_RUN  | normal push/pop traffic, status cross-check active
// BOPC_HOLD | after a flush: fetch blocked for HOLD_CYCLES
module bop_ctrl
  import bop_ctrl_pkg::*;
#(
  parameter int SIZE        = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int INIT_CYCLES = 2
) (
  input  logic                        s_clk_i,
  input  logic                        s_reset_i,
  input  logic                        s_flush_i,
  input  logic                        s_pred_i,
  input  logic [BOP_WIDTH-1:0]        s_pred_data_i,
  output logic                        s_pred_stall_o,
  input  logic                        s_eval_i,
  output logic                        s_eval_valid_o,
  output logic [BOP_WIDTH-1:0]        s_eval_data_o,
  output logic                        s_bop_push_o,
  output logic                        s_bop_pop_o,
  output logic                        s_bop_flush_o,
  output logic [BOP_WIDTH-1:0]        s_bop_data_o,
  input  logic [BOP_WIDTH-1:0]        s_bop_data_i,
  input  logic                        s_bop_ready_i,
  input  logic                        s_bop_full_i,
  output logic [$clog2(SIZE+1)-1:0]   s_inflight_o,
  output logic                        s_underflow_o,
  output logic                        s_mismatch_o
);

  localparam int CW   = $clog2(SIZE + 1);
  localparam int HMAX = (INIT_CYCLES > HOLD_CYCLES) ? INIT_CYCLES : HOLD_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] CNT_FULL  = CW'(SIZE);
  localparam logic [HW-1:0] HOLD_INIT = HW'(INIT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FLSH = HW'(HOLD_CYCLES - 1);

  bopc_state_t   r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic [HW-1:0] r_hold, w_next_hold;
  logic          r_underflow, r_mismatch;

  logic w_push, w_pop, w_stall, w_flush;
  logic w_set_uf, w_set_mis;

  // Output gating and next-state/credit computation for all FSM states.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_hold  = r_hold;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    w_set_uf     = 1'b0;
    w_set_mis    = 1'b0;

    if (s_reset_i) begin
      // State is being reinitialised; hold the BOP flushed and fetch stalled.
      w_flush = 1'b1;
      w_stall = 1'b1;
    end else begin
      case (r_state)
        BOPC_INIT: begin
          w_flush    = 1'b1;
          w_stall    = 1'b1;
          w_next_cnt = '0;
          if (r_hold == '0) w_next_state = BOPC_RUN;
          else              w_next_hold  = r_hold - HW'(1);
        end

        BOPC_RUN: begin
          if (s_flush_i) begin
            w_flush      = 1'b1;
            w_next_cnt   = '0;
            w_next_hold  = HOLD_FLSH;
            w_next_state = BOPC_HOLD;
          end else begin
            w_pop     = s_eval_i & s_bop_ready_i;
            // A pop in the same cycle frees the head, so a full BOP can still accept.
            w_push    = s_pred_i & (~s_bop_full_i | w_pop);
            w_stall   = s_pred_i & ~w_push;
            w_set_uf  = s_eval_i & ~s_bop_ready_i;
            w_set_mis = ((r_cnt == CNT_FULL) != s_bop_full_i) |
                        ((r_cnt == '0) & s_bop_ready_i);
            if (w_push & ~w_pop & (r_cnt != CNT_FULL))
              w_next_cnt = r_cnt + CW'(1);
            else if (w_pop & ~w_push & (r_cnt != '0))
              w_next_cnt = r_cnt - CW'(1);
          end
        end

        BOPC_HOLD: begin
          w_stall    = 1'b1;
          w_next_cnt = '0;
          if (s_flush_i)          w_next_hold  = HOLD_FLSH;
          else if (r_hold == '0)  w_next_state = BOPC_RUN;
          else                    w_next_hold  = r_hold - HW'(1);
        end

        default: begin
          w_flush      = 1'b1;
          w_stall      = 1'b1;
          w_next_cnt   = '0;
          w_next_hold  = HOLD_INIT;
          w_next_state = BOPC_INIT;
        end
      endcase
    end
  end

  // State, credit counter, hold timer and sticky error flags.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      r_state     <= BOPC_INIT;
      r_cnt       <= '0;
      r_hold      <= HOLD_INIT;
      r_underflow <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_hold      <= w_next_hold;
      r_underflow <= r_underflow | w_set_uf;
      r_mismatch  <= r_mismatch | w_set_mis;
    end
  end

  assign s_bop_push_o   = w_push;
  assign s_bop_pop_o    = w_pop;
  assign s_bop_flush_o  = w_flush;
  assign s_pred_stall_o = w_stall;
  assign s_eval_valid_o = w_pop;
  assign s_eval_data_o  = s_bop_data_i;
  assign s_bop_data_o   = s_pred_data_i;
  assign s_inflight_o   = r_cnt;
  assign s_underflow_o  = r_underflow;
  assign s_mismatch_o   = r_mismatch;

endmodule

// File: tb/tb_bop_ctrl.sv
// Bench for bop_ctrl with a two-entry behavioural BOP behind it. A queue-based
// reference model predicts every cycle; eval data goes through a scoreboard
// queue that a separate monitor drains whenever the DUT flags a valid eval.
module tb_bop_ctrl;
  import bop_ctrl_pkg::*;

  localparam int SIZE        = 2;
  localparam int HOLD_CYCLES = 1;
  localparam int INIT_CYCLES = 2;
  localparam int CW          = $clog2(SIZE + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush_i, pred_i, eval_i;
  logic [BOP_WIDTH-1:0] pred_data;
  logic                 stall_o, eval_valid_o, push_o, pop_o, bflush_o;
  logic [BOP_WIDTH-1:0] eval_data_o, bop_wdata;
  logic [CW-1:0]        inflight_o;
  logic                 underflow_o, mismatch_o;

  // behavioural BOP, SIZE=2, head in bm0
  logic [BOP_WIDTH-1:0] bm0 = '0, bm1 = '0;
  int                   bcnt = 0;
  bit                   force_full_low = 1'b0;
  logic                 bop_ready, bop_full;

  assign bop_ready = (bcnt > 0);
  assign bop_full  = (bcnt == SIZE) && !force_full_low;

  // reference model and scoreboard state
  logic [BOP_WIDTH-1:0] m_fifo[$];
  logic [BOP_WIDTH-1:0] sb_q[$];
  int                   m_init, m_block;
  bit                   m_uf, m_mis;
  int                   n_checks = 0;
  int                   n_err    = 0;

  always #5 clk = ~clk;

  bop_ctrl #(.SIZE(SIZE), .HOLD_CYCLES(HOLD_CYCLES), .INIT_CYCLES(INIT_CYCLES)) dut (
    .s_clk_i        (clk),
    .s_reset_i      (rst),
    .s_flush_i      (flush_i),
    .s_pred_i       (pred_i),
    .s_pred_data_i  (pred_data),
    .s_pred_stall_o (stall_o),
    .s_eval_i       (eval_i),
    .s_eval_valid_o (eval_valid_o),
    .s_eval_data_o  (eval_data_o),
    .s_bop_push_o   (push_o),
    .s_bop_pop_o    (pop_o),
    .s_bop_flush_o  (bflush_o),
    .s_bop_data_o   (bop_wdata),
    .s_bop_data_i   (bm0),
    .s_bop_ready_i  (bop_ready),
    .s_bop_full_i   (bop_full),
    .s_inflight_o   (inflight_o),
    .s_underflow_o  (underflow_o),
    .s_mismatch_o   (mismatch_o)
  );

  // BOP storage update
  always @(posedge clk) begin
    if (bflush_o) begin
      bcnt <= 0;
    end else if (push_o && pop_o) begin
      if (bcnt == 2) begin bm0 <= bm1; bm1 <= bop_wdata; end
      else if (bcnt == 1) bm0 <= bop_wdata;
      else begin bm0 <= bop_wdata; bcnt <= 1; end
    end else if (push_o) begin
      if (bcnt == 0) begin bm0 <= bop_wdata; bcnt <= 1; end
      else if (bcnt == 1) begin bm1 <= bop_wdata; bcnt <= 2; end
    end else if (pop_o && bcnt > 0) begin
      bm0  <= bm1;
      bcnt <= bcnt - 1;
    end
  end

  // scoreboard monitor: every DUT eval must match the next expected prediction
  always @(negedge clk) begin
    if (!rst && eval_valid_o) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL eval_unexpected: got valid data %h, none expected", eval_data_o);
      end else begin
        logic [BOP_WIDTH-1:0] exp_d;
        exp_d = sb_q.pop_front();
        if (eval_data_o !== exp_d) begin
          n_err++;
          $display("FAIL eval_data: got %h, expected %h", eval_data_o, exp_d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // One cycle: drive inputs, predict from the model, check at the negedge.
  task automatic step(input bit pv, input bit ev, input bit fv, input logic [BOP_WIDTH-1:0] d);
    bit e_push, e_pop, e_stall, e_flush, e_uf, e_mis, full_seen, ready_seen;
    int e_cnt;
    pred_i    = pv;
    eval_i    = ev;
    flush_i   = fv;
    pred_data = d;
    e_push = 0; e_pop = 0; e_stall = 0; e_flush = 0;
    e_cnt  = m_fifo.size();
    e_uf   = m_uf;
    e_mis  = m_mis;
    full_seen  = (m_fifo.size() == SIZE) && !force_full_low;
    ready_seen = (m_fifo.size() > 0);
    if (m_init > 0) begin
      e_flush = 1; e_stall = 1;
      m_init--;
    end else if (m_block > 0) begin
      e_stall = 1;
      if (fv) m_block = HOLD_CYCLES;
      else    m_block--;
    end else if (fv) begin
      e_flush = 1;
      m_fifo.delete();
      m_block = HOLD_CYCLES;
    end else begin
      if ((m_fifo.size() == SIZE) != full_seen) m_mis = 1;
      e_pop = ev && ready_seen;
      if (ev && !ready_seen) m_uf = 1;
      e_push  = pv && (!full_seen || e_pop);
      e_stall = pv && !e_push;
      if (e_pop)  sb_q.push_back(m_fifo.pop_front());
      if (e_push) m_fifo.push_back(d);
    end
    @(negedge clk);
    chk("push",       32'(push_o),       32'(e_push));
    chk("pop",        32'(pop_o),        32'(e_pop));
    chk("eval_valid", 32'(eval_valid_o), 32'(e_pop));
    chk("stall",      32'(stall_o),      32'(e_stall));
    chk("bop_flush",  32'(bflush_o),     32'(e_flush));
    chk("inflight",   32'(inflight_o),   32'(e_cnt));
    chk("underflow",  32'(underflow_o),  32'(e_uf));
    chk("mismatch",   32'(mismatch_o),   32'(e_mis));
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst = 1; pred_i = 0; eval_i = 0; flush_i = 0; pred_data = '0;
    force_full_low = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_flush", 32'(bflush_o),     32'd1);
      chk("rst_stall", 32'(stall_o),      32'd1);
      chk("rst_push",  32'(push_o),       32'd0);
      chk("rst_pop",   32'(pop_o),        32'd0);
      chk("rst_valid", 32'(eval_valid_o), 32'd0);
      @(posedge clk); #1;
    end
    rst = 0;
    m_fifo.delete();
    sb_q.delete();
    m_init  = INIT_CYCLES;
    m_block = 0;
    m_uf    = 0;
    m_mis   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();
    // INIT window then first RUN cycle
    repeat (INIT_CYCLES) step(0, 0, 0, '0);
    step(0, 0, 0, '0);

    // fill, stall on full, then simultaneous pop+push while full
    step(1, 0, 0, 32'hA);
    step(1, 0, 0, 32'hB);
    step(1, 0, 0, 32'hC);
    step(1, 1, 0, 32'hC);
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);

    // eval on empty BOP: sticky underflow
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);

    // flush with pred+eval on a full BOP, hold, then empty eval
    step(1, 0, 0, 32'hD);
    step(1, 0, 0, 32'hE);
    step(1, 1, 1, 32'hF);
    step(1, 0, 0, 32'hF);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    // fault injection: full flag lost while two entries are held
    step(1, 0, 0, 32'h11);
    step(1, 0, 0, 32'h22);
    force_full_low = 1;
    repeat (3) step(0, 0, 0, '0);
    force_full_low = 0;
    repeat (2) step(0, 0, 0, '0);

    // reset mid-operation with a full BOP, then random traffic
    reset_dut();
    repeat (INIT_CYCLES) step(0, 0, 0, '0);
    for (int i = 0; i < 10000; i++) begin
      bit fv, pv, ev;
      fv = ($urandom_range(0, 15) == 0);
      pv = ($urandom_range(0, 1) == 1);
      ev = ($urandom_range(0, 1) == 1) && (m_fifo.size() > 0);
      step(pv, ev, fv, $urandom);
    end
    for (int i = 0; i < 2 * SIZE + HOLD_CYCLES + 2; i++)
      step(0, (m_fifo.size() > 0), 0, '0);
    repeat (2) step(0, 0, 0, '0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
